fifo_stream_reader: RTL and testbench

//  Consumer end of the 16x9 distributed-RAM FIFO: drives rd_en, captures dout on valid and presents words as a valid/ready stream.

---
 rtl/fifo_stream_reader_pkg.sv | 13 +
 rtl/fifo_stream_reader_if.sv | 14 +
 rtl/fifo_stream_reader_skid.sv | 55 +++++
 rtl/fifo_stream_reader.sv | 84 ++++++++
 tb/tb_fifo_stream_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and pointer helper for the FIFO stream reader and its skid store.
package fifo_stream_reader_pkg;
  localparam int FIFO_WIDTH     = 9;
  localparam int FIFO_DEPTH     = 16;
  localparam int LAST_BIT       = 8;
  localparam int SKID_DEPTH_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  // Skid depths need not be powers of two, so pointers wrap explicitly.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream: payload, frame-end flag, handshake.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);
  logic [WIDTH-2:0] m_data;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_last, m_valid, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Circular skid store: push lands next cycle, head is a mux of registered storage.
// No internal backpressure; the caller never pushes when full nor pops when empty.
module fifo_stream_reader_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = SKID_DEPTH_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [OCC_W-1:0] occ_o,
  output logic [OCC_W-1:0] occ_next_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push_i) wptr_d = PTR_W'(wrap_inc(32'(wptr_q), DEPTH));
    if (pop_i)  rptr_d = PTR_W'(wrap_inc(32'(rptr_q), DEPTH));
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) mem_q[wptr_q] <= push_dat_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign head_dat_o = mem_q[rptr_q];
  assign occ_o      = occ_q;
  assign occ_next_o = occ_d;
endmodule

// File: rtl/fifo_stream_reader.sv
// Non-FWFT FIFO consumer: registered rd_en against skid credit, 3 cycles enable->m_valid, 1 word/cycle.
// m_ready throttles reads only through skid occupancy; stray read data is dropped and flagged.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_valid,
  input  logic                 fifo_empty,
  fifo_stream_reader_if.master m,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 err_unexpected,
  input  logic                 clr_err
);
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  logic             rd_en_q, rd_en_d;
  logic             inflight_q;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             err_q, err_d;
  logic [OCC_W-1:0] occ, occ_next;
  logic [WIDTH-1:0] head;
  logic [OCC_W:0]   credit_used;
  logic             full, push, pop, stray;

  assign full  = (occ == OCC_W'(SKID_DEPTH));
  assign push  = fifo_valid & inflight_q & ~full;
  assign stray = fifo_valid & (~inflight_q | full);
  assign pop   = m.m_valid & m.m_ready;

  fifo_stream_reader_skid #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (fifo_dout),
    .pop_i      (pop),
    .head_dat_o (head),
    .occ_o      (occ),
    .occ_next_o (occ_next)
  );

  assign m.m_valid = (occ != '0);
  assign m.m_data  = head[WIDTH-2:0];
  assign m.m_last  = head[WIDTH-1];

  always_comb begin
    // Next-cycle commitment: skid contents plus the read whose data lands next cycle.
    credit_used = {1'b0, occ_next} + (OCC_W+1)'(rd_en_q);
    rd_en_d     = enable & ~fifo_empty & (credit_used < (OCC_W+1)'(SKID_DEPTH));
    frame_d     = frame_q;
    if (pop && head[WIDTH-1]) frame_d = frame_q + CNT_W'(1);
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (stray)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      inflight_q <= 1'b0;
      frame_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      inflight_q <= rd_en_q;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign fifo_rd_en     = rd_en_q;
  assign frame_count    = frame_q;
  assign err_unexpected = err_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model, in-order scoreboard, directed and random phases.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        fifo_rd_en;
  logic [8:0]  fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic [15:0] frame_count;
  logic        err_unexpected;
  logic        clr_err;

  fifo_stream_reader_if #(.WIDTH(FIFO_WIDTH)) s_if ();

  fifo_stream_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifo_valid     (fifo_valid),
    .fifo_empty     (fifo_empty),
    .m              (s_if),
    .frame_count    (frame_count),
    .err_unexpected (err_unexpected),
    .clr_err        (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] fq[$];     // words held in the FIFO model
  logic [8:0] exp_q[$];  // words the stream still owes, in order
  int issued, accepted, max_out, delivered, bubbles, frame_exp;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rd;
    logic       mv;
    logic       cd;
    logic       last;
    logic [7:0] dat;
    logic [15:0] fc;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [8:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic score_beat();
    logic [8:0] got, want;
    got = {s_if.m_last, s_if.m_data};
    accepted++;
    delivered++;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_unexpected: got %0h, want no beat", got);
    end else begin
      want = exp_q.pop_front();
      check("beat_data", got, want);
      if (want[LAST_BIT]) frame_exp++;
    end
  endtask

  // One clock: score the pre-edge handshake, then model the FIFO's 1-cycle read.
  task automatic tick();
    bit rd, had;
    rd  = fifo_rd_en;
    had = (fq.size() != 0);
    if (s_if.m_valid && s_if.m_ready) score_beat();
    if (s_if.m_ready && !s_if.m_valid && exp_q.size() != 0) bubbles++;
    @(posedge clk);
    #1;
    if (rd && had) begin
      fifo_dout  = fq.pop_front();
      fifo_valid = 1'b1;
      issued++;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
    if (issued - accepted > max_out) max_out = issued - accepted;
  endtask

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    issued = 0; accepted = 0; max_out = 0; frame_exp = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    bit         seen;
    int         changes, iss0;

    rst_n = 1'b1; enable = 1'b0; fifo_valid = 1'b0; fifo_dout = '0;
    fifo_empty = 1'b1; clr_err = 1'b0; s_if.m_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_m_data", s_if.m_data, 0);
    check("rst_m_last", s_if.m_last, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err", err_unexpected, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    check("idle_rd_en", fifo_rd_en, 0);

    // {en, rdy, rd_en, m_valid, check_data, m_last, m_data, frame_count} after each edge
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 16'd0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 16'd0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 16'd0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 16'd0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 16'd0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    for (int i = 1; i <= 4; i++) load(9'(i));
    load(9'h105);
    for (int k = 0; k < 8; k++) begin
      enable       = vt[k].en;
      s_if.m_ready = vt[k].rdy;
      tick();
      check($sformatf("pre_rd_en[%0d]", k), fifo_rd_en, vt[k].rd);
      check($sformatf("pre_m_valid[%0d]", k), s_if.m_valid, vt[k].mv);
      if (vt[k].cd) begin
        check($sformatf("pre_m_data[%0d]", k), s_if.m_data, vt[k].dat);
        check($sformatf("pre_m_last[%0d]", k), s_if.m_last, vt[k].last);
      end
      check($sformatf("pre_frame_count[%0d]", k), frame_count, vt[k].fc);
    end

    // 16 words with m_ready toggling every cycle
    delivered = 0; max_out = 0;
    for (int i = 0; i < 16; i++) load({(i == 7 || i == 15) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      s_if.m_ready = ~s_if.m_ready;
      tick();
    end
    s_if.m_ready = 1'b1;
    tick(); tick();
    check("toggle_delivered", delivered, 16);
    check("toggle_frame_count", frame_count, frame_exp);
    check("toggle_outstanding_le3", (max_out <= 3), 1);

    // Full FIFO, sink stalled for 20 cycles
    s_if.m_ready = 1'b0;
    iss0 = issued; seen = 0; changes = 0; held = '0;
    for (int i = 0; i < 16; i++) load({(i == 15) ? 1'b1 : 1'b0, 8'(8'h40 + i)});
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_if.m_valid) begin
        if (!seen) begin held = s_if.m_data; seen = 1; end
        else if (s_if.m_data != held) changes++;
      end
    end
    check("stall_reads", issued - iss0, 3);
    check("stall_rd_en_low", fifo_rd_en, 0);
    check("stall_m_data", held, 8'h40);
    check("stall_data_changes", changes, 0);
    bubbles = 0; delivered = 0;
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("stall_release_bubbles", bubbles, 0);
    check("stall_release_delivered", delivered, 16);
    check("stall_frame_count", frame_count, frame_exp);

    // Stray read data and error clear priority
    enable = 1'b0;
    tick(); tick(); tick();
    fifo_dout = 9'h1AA; fifo_valid = 1'b1;
    tick();
    check("stray_err_set", err_unexpected, 1);
    check("stray_m_valid", s_if.m_valid, 0);
    check("stray_frame_count", frame_count, frame_exp);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_err", err_unexpected, 0);
    clr_err = 1'b1; fifo_dout = 9'h155; fifo_valid = 1'b1;
    tick(); clr_err = 1'b0;
    check("set_beats_clr", err_unexpected, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_err_again", err_unexpected, 0);

    // Reset mid-burst: skid holds two words and a third is in flight
    s_if.m_ready = 1'b0;
    load(9'h0A1); load(9'h0A2); load(9'h0A3);
    enable = 1'b1;
    repeat (4) tick();
    check("midrst_fifo_valid_pending", fifo_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", fifo_rd_en, 0);
    check("midrst_m_valid", s_if.m_valid, 0);
    check("midrst_m_data", s_if.m_data, 0);
    check("midrst_m_last", s_if.m_last, 0);
    check("midrst_frame_count", frame_count, 0);
    model_reset();
    fifo_empty = 1'b1;
    enable = 1'b0;
    rst_n = 1'b1;
    s_if.m_ready = 1'b1;
    tick();
    check("stale_err", err_unexpected, 1);
    check("stale_m_valid", s_if.m_valid, 0);
    tick();
    check("stale_not_forwarded", s_if.m_valid, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // enable dropped mid-burst
    delivered = 0;
    for (int i = 0; i < 10; i++) load({1'b0, 8'(8'h60 + i)});
    enable = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    repeat (12) tick();
    check("endrop_delivered", delivered, 5);
    check("endrop_m_valid", s_if.m_valid, 0);
    check("endrop_fifo_left", fq.size(), 5);

    // Random traffic against the in-order model
    max_out = 0;
    for (int c = 0; c < 1500; c++) begin
      enable       = ($urandom_range(0, 9) != 0);
      s_if.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fq.size() < FIFO_DEPTH)
        load({($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
      tick();
    end
    enable = 1'b1; s_if.m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick(); tick();
    check("rand_drain_left", exp_q.size(), 0);
    check("rand_m_valid_idle", s_if.m_valid, 0);
    check("rand_frame_count", frame_count, frame_exp);
    check("rand_outstanding_le3", (max_out <= 3), 1);
    check("rand_no_err", err_unexpected, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
